// File: rtl/bcp_mem_arbiter.sv
// Two-requester burst arbiter (host AXI engine, BCP engine) in front of a single-port clause RAM.
// Optional macro BCP_ARB_PRIO_EN: requester 1 wins every tie instead of round-robin.
module bcp_mem_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic [1:0]          req_valid,
   output logic [1:0]          req_ready,
   input  logic [1:0]          req_we,
   input  logic [2*ADDR_W-1:0] req_addr,
   input  logic [15:0]         req_len,
   input  logic [2*DATA_W-1:0] wr_data,
   input  logic [1:0]          wr_valid,
   output logic [1:0]          wr_ready,
   output logic [DATA_W-1:0]   rd_data,
   output logic [1:0]          rd_valid,
   output logic [1:0]          done,
   output logic                busy,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

   state_t            state_q, state_d;
   logic              win;
   logic              w_q;
   logic [1:0]        w_mask;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        len_q;
   logic [7:0]        count_q;
   logic [1:0]        done_q;
   logic [1:0]        rd_valid_q;
   logic              wr_beat;
   logic              last_beat;
`ifndef BCP_ARB_PRIO_EN
   logic              last_q;
`endif

   // Winner only matters on a tie; a lone requester always wins.
   always_comb begin
`ifdef BCP_ARB_PRIO_EN
      win = req_valid[1];
`else
      win = (&req_valid) ? ~last_q : req_valid[1];
`endif
   end

   assign w_mask    = w_q ? 2'b10 : 2'b01;
   assign wr_beat   = (state_q == WRITE) && wr_valid[w_q];
   assign last_beat = (count_q == len_q);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|req_valid) state_d = (win ? req_we[1] : req_we[0]) ? WRITE : READ;
         WRITE:   if (wr_beat && last_beat) state_d = IDLE;
         READ:    if (last_beat) state_d = DRAIN;
         DRAIN:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Combinational outputs are forced low while ARESET is high so nothing reaches the RAM.
   always_comb begin
      req_ready = '0;
      wr_ready  = '0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      mem_addr  = addr_q + ADDR_W'(count_q);
      if (!ARESET) begin
         case (state_q)
            IDLE: if (|req_valid) req_ready = win ? 2'b10 : 2'b01;
            WRITE: begin
               wr_ready  = w_mask;
               mem_en    = wr_valid[w_q];
               mem_we    = wr_valid[w_q];
               mem_wdata = w_q ? wr_data[2*DATA_W-1:DATA_W] : wr_data[DATA_W-1:0];
            end
            READ:    mem_en = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q    <= IDLE;
         w_q        <= 1'b0;
         addr_q     <= '0;
         len_q      <= '0;
         count_q    <= '0;
         done_q     <= '0;
         rd_valid_q <= '0;
`ifndef BCP_ARB_PRIO_EN
         last_q     <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         done_q     <= '0;
         rd_valid_q <= '0;
         case (state_q)
            IDLE: if (|req_valid) begin
               w_q     <= win;
               addr_q  <= win ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
               len_q   <= win ? req_len[15:8] : req_len[7:0];
               count_q <= '0;
`ifndef BCP_ARB_PRIO_EN
               last_q  <= win;
`endif
            end
            WRITE: if (wr_beat) begin
               count_q <= count_q + 8'd1;
               if (last_beat) done_q <= w_mask;
            end
            // RAM returns data one cycle after each issue; DRAIN covers the final beat.
            READ: begin
               rd_valid_q <= w_mask;
               count_q    <= count_q + 8'd1;
            end
            DRAIN:   done_q <= w_mask;
            default: ;
         endcase
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_data  = (|rd_valid_q) ? mem_rdata : '0;
   assign done     = done_q;
   assign busy     = (state_q != IDLE);

endmodule
